// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the decode-stage hazard controller.
// The master side is the pipeline; the slave side is hazard_control_unit.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 32'd16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_jr;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_access;
    logic             dmem_ready;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_flush;
    logic [1:0]       fsm_state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_jr,
        output ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
        output mem_rd, mem_reg_write, mem_mem_read, mem_access, dmem_ready,
        input  forward_a, forward_b, pc_write, ifid_write, ifid_flush, idex_flush,
        input  exmem_write, memwb_flush, fsm_state, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_jr,
        input  ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
        input  mem_rd, mem_reg_write, mem_mem_read, mem_access, dmem_ready,
        output forward_a, forward_b, pc_write, ifid_write, ifid_flush, idex_flush,
        output exmem_write, memwb_flush, fsm_state, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard controller: operand forwarding, load-use/branch/jump handling,
// data-memory freeze with watchdog, and saturating stall/flush counters.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 32'd255,
    parameter int unsigned CNT_W       = 32'd16
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_control_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [15:0]      LP_TIMEOUT = MEM_TIMEOUT[15:0];
    localparam logic [15:0]      LP_WD_ONE  = 16'd1;
    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_wd;
    logic [15:0]      w_wd_next;
    logic             r_mem_timeout;
    logic             w_set_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_uses_rs;
    logic             w_lu;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_exmem_write;
    logic             w_memwb_flush;

    // EX wins over MEM; a load in EX has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] ex_rd,
        input logic       ex_rw,
        input logic       ex_mr,
        input logic [4:0] mem_rd,
        input logic       mem_rw,
        input logic       mem_mr
    );
        logic [1:0] sel;
        if (r == 5'd0) begin
            sel = 2'd0;
        end else if (ex_rw && (ex_rd == r) && !ex_mr) begin
            sel = 2'd1;
        end else if (mem_rw && (mem_rd == r)) begin
            sel = mem_mr ? 2'd3 : 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    assign w_fwd_a   = fwd_sel(bus.id_rs, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                               bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read);
    assign w_fwd_b   = fwd_sel(bus.id_rt, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                               bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read);
    assign w_uses_rs = bus.id_uses_rs | bus.id_jr;
    assign w_lu      = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                       ((w_uses_rs && (bus.ex_rd == bus.id_rs)) ||
                        (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    // Next-state, watchdog and pipeline-control decode.
    always_comb begin
        w_next_state  = r_state;
        w_wd_next     = r_wd;
        w_set_timeout = 1'b0;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_write = 1'b1;
        w_memwb_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_access && !bus.dmem_ready) begin
                    w_next_state  = ST_MEM_WAIT;
                    w_wd_next     = LP_WD_ONE;
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_exmem_write = 1'b0;
                    w_memwb_flush = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                end else if (w_lu) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_flush  = 1'b1;
                end else if (bus.id_jump || bus.id_jr) begin
                    w_ifid_flush  = 1'b1;
                end else begin
                    w_next_state  = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_exmem_write = 1'b0;
                w_memwb_flush = 1'b1;
                if (bus.dmem_ready) begin
                    // The completing access must move on into MEM/WB.
                    w_next_state  = ST_RUN;
                    w_wd_next     = 16'd0;
                    w_exmem_write = 1'b1;
                    w_memwb_flush = 1'b0;
                end else if (r_wd >= LP_TIMEOUT) begin
                    w_next_state  = ST_ERR;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wd_next     = r_wd + LP_WD_ONE;
                end
            end
            ST_ERR: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_exmem_write = 1'b0;
                w_memwb_flush = 1'b1;
            end
            default: begin
                w_next_state  = ST_ERR;
                w_set_timeout = 1'b1;
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_exmem_write = 1'b0;
                w_memwb_flush = 1'b1;
            end
        endcase
    end

    // State, watchdog, sticky timeout flag and saturating counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_wd          <= 16'd0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= {CNT_W{1'b0}};
            r_flush_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state       <= w_next_state;
            r_wd          <= w_wd_next;
            r_mem_timeout <= r_mem_timeout | w_set_timeout;
            if (!w_pc_write && (r_stall_cnt != LP_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_ifid_flush && (r_flush_cnt != LP_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    // While reset is held the pipeline is parked: all stages flushed, nothing written.
    always_comb begin
        if (!reset) begin
            bus.forward_a   = 2'd0;
            bus.forward_b   = 2'd0;
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_write = 1'b0;
            bus.memwb_flush = 1'b1;
        end else begin
            bus.forward_a   = w_fwd_a;
            bus.forward_b   = w_fwd_b;
            bus.pc_write    = w_pc_write;
            bus.ifid_write  = w_ifid_write;
            bus.ifid_flush  = w_ifid_flush;
            bus.idex_flush  = w_idex_flush;
            bus.exmem_write = w_exmem_write;
            bus.memwb_flush = w_memwb_flush;
        end
    end

    assign bus.fsm_state   = r_state;
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule
